pmod_cls_text_sequencer: RTL and testbench

- Upstream command sequencer for the PMOD CLS SPI driver.
- Latches two 16-character text lines and issues the driver's clear, line1 and line2 command strobes in order, using the driver's o_command_ready handshake.
- Refreshes on explicit request, or periodically when the input text differs from the text last written.
- Runs in the same clock/clock-enable domain as the driver.

---
 rtl/pmod_cls_text_sequencer.sv | 155 +++++++++++++++
 tb/tb_pmod_cls_text_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_cls_text_sequencer.sv
// Command sequencer in front of the PMOD CLS SPI driver. Latches two 16-character
// lines and walks the driver through clear / line1 / line2 using its ready handshake.
//
// state        | meaning
// ST_IDLE      | waiting for a pending request while the driver is ready
// ST_CLR_CMD   | clear strobe high until the driver is seen ready
// ST_CLR_BUSY  | clear accepted, waiting for ready to drop
// ST_CLR_DONE  | waiting for ready to return after clear
// ST_L1_CMD    | line-1 strobe high until the driver is seen ready
// ST_L1_BUSY   | line-1 accepted, waiting for ready to drop
// ST_L1_DONE   | waiting for ready to return after line-1
// ST_L2_CMD    | line-2 strobe high until the driver is seen ready
// ST_L2_BUSY   | line-2 accepted, waiting for ready to drop
// ST_L2_DONE   | waiting for ready to return after line-2
module pmod_cls_text_sequencer #(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int parm_refresh_ms      = 200,
    parameter int parm_clear_on_update = 0,
    parameter int parm_watchdog_bits   = 16
) (
    input  logic         i_ext_spi_clk_x,
    input  logic         i_srst,
    input  logic         i_spi_ce_4x,
    input  logic         i_update_req,
    input  logic [127:0] i_dat_ascii_line1,
    input  logic [127:0] i_dat_ascii_line2,
    input  logic         i_command_ready,
    output logic         o_cmd_wr_clear_display,
    output logic         o_cmd_wr_text_line1,
    output logic         o_cmd_wr_text_line2,
    output logic [127:0] o_dat_ascii_line1,
    output logic [127:0] o_dat_ascii_line2,
    output logic         o_seq_busy,
    output logic         o_timeout
);
    localparam int c_period = (parm_fast_simulation != 0) ? (FCLK_ce / 1000)
                                                          : (FCLK_ce / 1000 * parm_refresh_ms);
    localparam int c_tmr_bits = (c_period > 1) ? $clog2(c_period) : 1;
    localparam logic [c_tmr_bits-1:0] c_tmr_last = c_tmr_bits'(c_period - 1);
    localparam logic [parm_watchdog_bits-1:0] c_wd_trip = ~(parm_watchdog_bits'(1));
    localparam logic [127:0] c_spaces = {16{8'h20}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_CMD, ST_CLR_BUSY, ST_CLR_DONE,
        ST_L1_CMD,  ST_L1_BUSY,  ST_L1_DONE,
        ST_L2_CMD,  ST_L2_BUSY,  ST_L2_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic                          first_q, first_d;
    logic                          pending_q, pending_d;
    logic [c_tmr_bits-1:0]         tmr_q, tmr_d;
    logic [parm_watchdog_bits-1:0] wdog_q, wdog_d;
    logic                          timeout_q, timeout_d;
    logic [127:0]                  line1_q, line1_d;
    logic [127:0]                  line2_q, line2_d;

    logic wait_st;
    logic wd_trip;
    logic leave_idle;
    logic tmr_wrap;
    logic text_changed;

    always_ff @(posedge i_ext_spi_clk_x) begin
        if (i_srst) begin
            state_q   <= ST_IDLE;
            first_q   <= 1'b1;
            pending_q <= 1'b0;
            tmr_q     <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            line1_q   <= c_spaces;
            line2_q   <= c_spaces;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            pending_q <= pending_d;
            tmr_q     <= tmr_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
        end
    end

    assign wait_st = (state_q == ST_CLR_BUSY) || (state_q == ST_CLR_DONE) ||
                     (state_q == ST_L1_BUSY)  || (state_q == ST_L1_DONE)  ||
                     (state_q == ST_L2_BUSY)  || (state_q == ST_L2_DONE);

    always_comb begin
        state_d = state_q;
        wd_trip = 1'b0;
        if (i_spi_ce_4x) begin
            case (state_q)
                ST_IDLE:     if (pending_q && i_command_ready)
                                 state_d = (first_q || (parm_clear_on_update != 0)) ? ST_CLR_CMD : ST_L1_CMD;
                ST_CLR_CMD:  if (i_command_ready)  state_d = ST_CLR_BUSY;
                ST_CLR_BUSY: if (!i_command_ready) state_d = ST_CLR_DONE;
                ST_CLR_DONE: if (i_command_ready)  state_d = ST_L1_CMD;
                ST_L1_CMD:   if (i_command_ready)  state_d = ST_L1_BUSY;
                ST_L1_BUSY:  if (!i_command_ready) state_d = ST_L1_DONE;
                ST_L1_DONE:  if (i_command_ready)  state_d = ST_L2_CMD;
                ST_L2_CMD:   if (i_command_ready)  state_d = ST_L2_BUSY;
                ST_L2_BUSY:  if (!i_command_ready) state_d = ST_L2_DONE;
                ST_L2_DONE:  if (i_command_ready)  state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
            // trip on the ce cycle that would bring the counter to all-ones
            if (wait_st && (state_d == state_q) && (wdog_q == c_wd_trip)) begin
                wd_trip = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        leave_idle   = i_spi_ce_4x && (state_q == ST_IDLE) && (state_d != ST_IDLE);
        tmr_wrap     = i_spi_ce_4x && (tmr_q == c_tmr_last);
        text_changed = (i_dat_ascii_line1 != line1_q) || (i_dat_ascii_line2 != line2_q);

        tmr_d = tmr_q;
        if (i_spi_ce_4x)
            tmr_d = tmr_wrap ? '0 : tmr_q + 1'b1;

        pending_d = (pending_q && !leave_idle) || i_update_req || (tmr_wrap && text_changed);

        line1_d = leave_idle ? i_dat_ascii_line1 : line1_q;
        line2_d = leave_idle ? i_dat_ascii_line2 : line2_q;

        // a watchdog abort keeps first_q set so the retry starts with a clear
        first_d = first_q;
        if (i_spi_ce_4x && (state_q == ST_CLR_DONE) && (state_d == ST_L1_CMD))
            first_d = 1'b0;

        wdog_d = wdog_q;
        if (state_d != state_q)
            wdog_d = '0;
        else if (i_spi_ce_4x && wait_st)
            wdog_d = wdog_q + 1'b1;

        timeout_d = timeout_q || wd_trip;
    end

    always_comb begin
        o_cmd_wr_clear_display = (state_q == ST_CLR_CMD);
        o_cmd_wr_text_line1    = (state_q == ST_L1_CMD);
        o_cmd_wr_text_line2    = (state_q == ST_L2_CMD);
        o_seq_busy             = (state_q != ST_IDLE);
        o_timeout              = timeout_q;
        o_dat_ascii_line1      = line1_q;
        o_dat_ascii_line2      = line2_q;
    end
endmodule

// File: tb/tb_pmod_cls_text_sequencer.sv
// Bench for pmod_cls_text_sequencer: three instances (clear-once, clear-always with
// fast refresh, short watchdog) each driven by a simple SPI-driver ready model.
module tb_pmod_cls_text_sequencer;
    localparam int c_clr = 0;
    localparam int c_l1  = 1;
    localparam int c_l2  = 2;
    localparam logic [127:0] c_spaces = {16{8'h20}};

    typedef struct {
        int           inst;
        int           code;
        logic [127:0] d1;
        logic [127:0] d2;
    } exp_t;

    typedef struct {
        int           inst;
        logic [127:0] l1;
        logic [127:0] l2;
        bit           exp_clr;
    } vec_t;

    logic         clk = 1'b0;
    logic         ce  = 1'b0;
    logic [2:0]   srst;
    logic [2:0]   req;
    logic [2:0]   hang;
    logic [127:0] in1 [3];
    logic [127:0] in2 [3];
    wire  [2:0]   rdy;
    wire  [2:0]   s_clr;
    wire  [2:0]   s_l1;
    wire  [2:0]   s_l2;
    wire  [2:0]   busy;
    wire  [2:0]   tmo;
    wire  [127:0] out1 [3];
    wire  [127:0] out2 [3];

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        ce = ~ce;
    end

    pmod_cls_text_sequencer #(
        .parm_fast_simulation(0), .FCLK_ce(2500000), .parm_refresh_ms(200),
        .parm_clear_on_update(0), .parm_watchdog_bits(16)
    ) dut0 (
        .i_ext_spi_clk_x(clk), .i_srst(srst[0]), .i_spi_ce_4x(ce), .i_update_req(req[0]),
        .i_dat_ascii_line1(in1[0]), .i_dat_ascii_line2(in2[0]), .i_command_ready(rdy[0]),
        .o_cmd_wr_clear_display(s_clr[0]), .o_cmd_wr_text_line1(s_l1[0]), .o_cmd_wr_text_line2(s_l2[0]),
        .o_dat_ascii_line1(out1[0]), .o_dat_ascii_line2(out2[0]), .o_seq_busy(busy[0]), .o_timeout(tmo[0])
    );

    pmod_cls_text_sequencer #(
        .parm_fast_simulation(1), .FCLK_ce(2500000), .parm_refresh_ms(200),
        .parm_clear_on_update(1), .parm_watchdog_bits(16)
    ) dut1 (
        .i_ext_spi_clk_x(clk), .i_srst(srst[1]), .i_spi_ce_4x(ce), .i_update_req(req[1]),
        .i_dat_ascii_line1(in1[1]), .i_dat_ascii_line2(in2[1]), .i_command_ready(rdy[1]),
        .o_cmd_wr_clear_display(s_clr[1]), .o_cmd_wr_text_line1(s_l1[1]), .o_cmd_wr_text_line2(s_l2[1]),
        .o_dat_ascii_line1(out1[1]), .o_dat_ascii_line2(out2[1]), .o_seq_busy(busy[1]), .o_timeout(tmo[1])
    );

    pmod_cls_text_sequencer #(
        .parm_fast_simulation(0), .FCLK_ce(2500000), .parm_refresh_ms(200),
        .parm_clear_on_update(0), .parm_watchdog_bits(4)
    ) dut2 (
        .i_ext_spi_clk_x(clk), .i_srst(srst[2]), .i_spi_ce_4x(ce), .i_update_req(req[2]),
        .i_dat_ascii_line1(in1[2]), .i_dat_ascii_line2(in2[2]), .i_command_ready(rdy[2]),
        .o_cmd_wr_clear_display(s_clr[2]), .o_cmd_wr_text_line1(s_l1[2]), .o_cmd_wr_text_line2(s_l2[2]),
        .o_dat_ascii_line1(out1[2]), .o_dat_ascii_line2(out2[2]), .o_seq_busy(busy[2]), .o_timeout(tmo[2])
    );

    // Driver model: ready drops after accepting a strobe and returns c_lat ce later;
    // with hang set it stays low until hang is released.
    for (genvar g = 0; g < 3; g++) begin : g_drv
        localparam int c_lat = (g == 2) ? 6 : 20;
        int   cnt;
        logic hold;
        always @(posedge clk) begin
            if (srst[g]) begin
                cnt  <= 0;
                hold <= 1'b0;
            end else begin
                if (!hang[g]) hold <= 1'b0;
                if (ce) begin
                    if (cnt != 0) cnt <= cnt - 1;
                    else if (rdy[g] && (s_clr[g] || s_l1[g] || s_l2[g])) begin
                        cnt <= c_lat;
                        if (hang[g]) hold <= 1'b1;
                    end
                end
            end
        end
        assign rdy[g] = (cnt == 0) && !hold;
    end

    function automatic logic [127:0] pad16(input string s);
        logic [127:0] r;
        r = c_spaces;
        for (int i = 0; i < 16 && i < s.len(); i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic see_strobe(input int g);
        int   code;
        exp_t e;
        code = s_clr[g] ? c_clr : (s_l1[g] ? c_l1 : c_l2);
        chk($sformatf("strobe_onehot_%0d", g), int'(s_clr[g]) + int'(s_l1[g]) + int'(s_l2[g]), 1);
        chk($sformatf("strobe_ready_%0d", g), rdy[g], 1'b1);
        chk($sformatf("strobe_busy_%0d", g), busy[g], 1'b1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: inst %0d code %0d, expected none", g, code);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("strobe_order_%0d", g), g * 4 + code, e.inst * 4 + e.code);
            chk($sformatf("strobe_line1_%0d", g), out1[g], e.d1);
            chk($sformatf("strobe_line2_%0d", g), out2[g], e.d2);
        end
    endtask

    always @(negedge clk) begin
        if (ce)
            for (int g = 0; g < 3; g++)
                if (s_clr[g] || s_l1[g] || s_l2[g]) see_strobe(g);
    end

    task automatic push_one(input int g, input int code, input logic [127:0] d1, input logic [127:0] d2);
        exp_t e;
        e.inst = g;
        e.code = code;
        e.d1   = d1;
        e.d2   = d2;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int g, input bit with_clr, input logic [127:0] d1, input logic [127:0] d2);
        if (with_clr) push_one(g, c_clr, d1, d2);
        push_one(g, c_l1, d1, d2);
        push_one(g, c_l2, d1, d2);
    endtask

    task automatic pulse_req(input int g);
        @(posedge clk);
        #1 req[g] = 1'b1;
        @(posedge clk);
        #1 req[g] = 1'b0;
    endtask

    task automatic wait_busy(input int g);
        for (int i = 0; i < 20; i++) begin
            if (busy[g]) break;
            @(posedge clk);
            #1;
        end
        chk($sformatf("busy_rise_%0d", g), busy[g], 1'b1);
    endtask

    task automatic wait_drain(input int g, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy[g]) break;
        end
        chk($sformatf("drain_left_%0d", g), exp_q.size(), 0);
        chk($sformatf("drain_busy_%0d", g), busy[g], 1'b0);
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t         vecs[5];
        int           g;
        int           n;
        int           cnt;
        logic [127:0] a;
        logic [127:0] b;

        srst = '1;
        req  = '0;
        hang = 3'b100;
        for (int i = 0; i < 3; i++) begin
            in1[i] = c_spaces;
            in2[i] = c_spaces;
        end
        vecs[0] = '{0, pad16("BOOT LINE ONE"), pad16("BOOT LINE TWO"), 1'b1};
        vecs[1] = '{0, pad16("SECOND UPDATE"), pad16("0123456789ABCDEF"), 1'b0};
        vecs[2] = '{0, pad16("THIRD"), pad16(""), 1'b0};
        vecs[3] = '{1, pad16("ABC"), pad16("DEF"), 1'b1};
        vecs[4] = '{1, pad16("LINE ONE"), pad16("HELLO"), 1'b1};

        repeat (4) @(posedge clk);
        #1 srst = '0;

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_strobes_%0d", i), {s_clr[i], s_l1[i], s_l2[i]}, 3'b000);
            chk($sformatf("rst_busy_%0d", i), busy[i], 1'b0);
            chk($sformatf("rst_timeout_%0d", i), tmo[i], 1'b0);
            chk($sformatf("rst_line1_%0d", i), out1[i], c_spaces);
            chk($sformatf("rst_line2_%0d", i), out2[i], c_spaces);
        end
        hang = 3'b000;

        // table: boot flow, later updates with and without clear-on-update
        for (int i = 0; i < 5; i++) begin
            g = vecs[i].inst;
            in1[g] = vecs[i].l1;
            in2[g] = vecs[i].l2;
            push_seq(g, vecs[i].exp_clr, vecs[i].l1, vecs[i].l2);
            pulse_req(g);
            wait_busy(g);
            if (g == 0) begin
                in1[g] = ~vecs[i].l1;
                in2[g] = ~vecs[i].l2;
            end
            wait_drain(g, 2000);
            chk($sformatf("vec%0d_line1", i), out1[g], vecs[i].l1);
            chk($sformatf("vec%0d_line2", i), out2[g], vecs[i].l2);
        end

        // request arriving in ST_L1_DONE runs exactly one more L1/L2 pass
        a = pad16("FIRST PASS");
        b = pad16("SEQ A");
        in1[0] = a;
        in2[0] = b;
        push_seq(0, 1'b0, a, b);
        pulse_req(0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (s_l1[0]) break;
        end
        repeat (8) @(posedge clk);
        #1;
        in1[0] = pad16("SECOND PASS");
        in2[0] = pad16("SEQ B");
        push_seq(0, 1'b0, pad16("SECOND PASS"), pad16("SEQ B"));
        pulse_req(0);
        wait_drain(0, 3000);
        repeat (400) @(posedge clk);
        #1;
        chk("busy_req_line1", out1[0], pad16("SECOND PASS"));
        chk("busy_req_idle", busy[0], 1'b0);

        // periodic change detect on the fast-refresh instance
        in2[1] = pad16("WORLD");
        push_seq(1, 1'b1, pad16("LINE ONE"), pad16("WORLD"));
        n = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            if (ce) n++;
            #1;
            if (busy[1]) break;
        end
        chk_range("change_detect_ce", n, 1, 2502);
        wait_drain(1, 2000);
        chk("change_line2", out2[1], pad16("WORLD"));
        cnt = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (busy[1]) cnt++;
        end
        chk("quiet_no_update", cnt, 0);

        // watchdog: driver never returns ready after the clear strobe
        hang[2] = 1'b1;
        in1[2] = pad16("WD ONE");
        in2[2] = pad16("WD TWO");
        push_one(2, c_clr, pad16("WD ONE"), pad16("WD TWO"));
        pulse_req(2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (ce) n++;
            #1;
            if (tmo[2]) break;
        end
        chk("wd_timeout", tmo[2], 1'b1);
        chk_range("wd_latency_ce", n, 15, 18);
        chk("wd_idle", busy[2], 1'b0);
        repeat (40) @(posedge clk);
        #1;
        hang[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        in1[2] = pad16("RETRY");
        push_seq(2, 1'b1, pad16("RETRY"), pad16("WD TWO"));
        pulse_req(2);
        wait_drain(2, 2000);
        chk("wd_sticky", tmo[2], 1'b1);
        in1[2] = pad16("AFTER RETRY");
        push_seq(2, 1'b0, pad16("AFTER RETRY"), pad16("WD TWO"));
        pulse_req(2);
        wait_drain(2, 2000);

        // reset while in ST_L1_CMD
        in1[0] = pad16("RESET ME");
        in2[0] = pad16("NOW");
        pulse_req(0);
        wait_busy(0);
        srst[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_strobes", {s_clr[0], s_l1[0], s_l2[0]}, 3'b000);
        chk("mrst_busy", busy[0], 1'b0);
        chk("mrst_timeout", tmo[0], 1'b0);
        chk("mrst_line1", out1[0], c_spaces);
        chk("mrst_line2", out2[0], c_spaces);
        srst[0] = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("mrst_quiet", busy[0], 1'b0);
        push_seq(0, 1'b1, pad16("RESET ME"), pad16("NOW"));
        pulse_req(0);
        wait_drain(0, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
